// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ byte requesters and times each frame internally.
// Build option: define UART_TXARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 20,
    parameter int FRAME_BITS   = 11,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_en,
    output logic [7:0]                 data_in,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       frame_done
);

    localparam int FRAME_CYCLES = CLKS_PER_BIT * FRAME_BITS;
    localparam int CNT_MAX      = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
    localparam int CW           = $clog2(CNT_MAX + 1);
    localparam int IDW          = $clog2(NUM_REQ);
    localparam int GAP_LOAD     = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    typedef enum logic [1:0] {IDLE, START, SEND, GAP} state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [7:0]     data_q, data_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] idx;
    logic [7:0]     win_byte;
    logic           found;
    logic           handshake;
`ifndef UART_TXARB_FIXED_PRIO_EN
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW:0]   sum;
`endif

    // Winner search: rotating start just after the last grant, or plain lowest-index priority.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
`ifndef UART_TXARB_FIXED_PRIO_EN
        sum    = '0;
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef UART_TXARB_FIXED_PRIO_EN
            idx = IDW'(k);
`else
            sum = {1'b0, rr_ptr_q} + (IDW+1)'(k + 1);
            idx = (sum >= (IDW+1)'(NUM_REQ)) ? IDW'(sum - (IDW+1)'(NUM_REQ)) : IDW'(sum);
`endif
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        win_byte = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (winner == IDW'(k)) win_byte = req_data[8*k +: 8];
        end
    end

    always_comb begin
        req_ready = '0;
        if (reset && state_q == IDLE && found) req_ready[winner] = 1'b1;
    end

    assign handshake = |req_ready;

    // The counter is loaded at the handshake so that START already counts as the first frame cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        grant_d    = grant_q;
`ifndef UART_TXARB_FIXED_PRIO_EN
        rr_ptr_d   = rr_ptr_q;
`endif
        tx_en      = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (handshake) begin
                    data_d   = win_byte;
                    grant_d  = winner;
`ifndef UART_TXARB_FIXED_PRIO_EN
                    rr_ptr_d = winner;
`endif
                    cnt_d    = CW'(FRAME_CYCLES - 1);
                    state_d  = START;
                end
            end
            START: begin
                tx_en   = 1'b1;
                cnt_d   = cnt_q - CW'(1);
                state_d = SEND;
            end
            SEND: begin
                if (cnt_q == '0) begin
                    frame_done = 1'b1;
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = CW'(GAP_LOAD);
                        state_d = GAP;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            data_q   <= '0;
            grant_q  <= '0;
`ifndef UART_TXARB_FIXED_PRIO_EN
            rr_ptr_q <= IDW'(NUM_REQ - 1);
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            grant_q  <= grant_d;
`ifndef UART_TXARB_FIXED_PRIO_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    assign data_in  = data_q;
    assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scenario tasks plus a per-cycle comparison against a timestamp-based reference model.
// Honours UART_TXARB_FIXED_PRIO_EN the same way the design does.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int CLKS_PER_BIT = 20;
    localparam int FRAME_BITS   = 11;
    localparam int GAP_CYCLES   = 2;
    localparam int IDW          = $clog2(NUM_REQ);
    localparam int FRAME        = CLKS_PER_BIT * FRAME_BITS;
    localparam int SLOT         = FRAME + GAP_CYCLES + 1;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [8*NUM_REQ-1:0] req_data = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_en;
    logic [7:0]           data_in;
    logic                 busy;
    logic [IDW-1:0]       grant_id;
    logic                 frame_done;

    int tests = 0;
    int fails = 0;
    int tbCyc = 0;
    bit monOn = 0;

    logic [7:0] reqQ[NUM_REQ][$];

    always #5 clock = ~clock;

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ), .CLKS_PER_BIT(CLKS_PER_BIT),
        .FRAME_BITS(FRAME_BITS), .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_en(tx_en), .data_in(data_in), .busy(busy),
        .grant_id(grant_id), .frame_done(frame_done)
    );

    // Reference model: remembers only when the last handshake happened and derives everything from that timestamp.
    int         cyc = 0;
    bit         hsValid = 0;
    int         hsCyc = 0;
    logic [7:0] mData = '0;
    int         mGrant = 0;
    int         mLast = NUM_REQ - 1;
    bit         hsEdge = 0;
    int         hsId = 0;
    int         hsTotal = 0;

    function automatic bit mBusy();
        return hsValid && (cyc > hsCyc) && (cyc <= hsCyc + FRAME + GAP_CYCLES);
    endfunction

    function automatic int mWinner();
        for (int k = 1; k <= NUM_REQ; k++) begin
`ifdef UART_TXARB_FIXED_PRIO_EN
            int i = k - 1;
`else
            int i = (mLast + k) % NUM_REQ;
`endif
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [NUM_REQ-1:0] mReady();
        int w;
        if (!reset || mBusy()) return '0;
        w = mWinner();
        if (w < 0) return '0;
        return NUM_REQ'(1) << w;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            hsValid = 0;
            mData   = '0;
            mGrant  = 0;
            mLast   = NUM_REQ - 1;
            hsEdge  = 0;
        end else begin
            hsEdge = 0;
            if (mReady() != '0) begin
                hsId    = mWinner();
                hsEdge  = 1;
                hsValid = 1;
                hsCyc   = cyc;
                mData   = req_data[8*hsId +: 8];
                mGrant  = hsId;
                mLast   = hsId;
                hsTotal++;
            end
            cyc++;
        end
    end

    always @(negedge clock) begin
        if (monOn) begin
            tests++;
            if (req_ready !== mReady()) begin
                fails++;
                $display("[TB] FAIL mon_req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, mReady());
            end
            tests++;
            if (tx_en !== (hsValid && cyc == hsCyc + 1)) begin
                fails++;
                $display("[TB] FAIL mon_tx_en cyc=%0d got=%b exp=%b", cyc, tx_en, hsValid && cyc == hsCyc + 1);
            end
            tests++;
            if (frame_done !== (hsValid && cyc == hsCyc + FRAME)) begin
                fails++;
                $display("[TB] FAIL mon_frame_done cyc=%0d got=%b exp=%b", cyc, frame_done, hsValid && cyc == hsCyc + FRAME);
            end
            tests++;
            if (busy !== mBusy()) begin
                fails++;
                $display("[TB] FAIL mon_busy cyc=%0d got=%b exp=%b", cyc, busy, mBusy());
            end
            tests++;
            if (data_in !== mData) begin
                fails++;
                $display("[TB] FAIL mon_data_in cyc=%0d got=%h exp=%h", cyc, data_in, mData);
            end
            tests++;
            if (grant_id !== IDW'(mGrant)) begin
                fails++;
                $display("[TB] FAIL mon_grant_id cyc=%0d got=%0d exp=%0d", cyc, grant_id, mGrant);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        tbCyc++;
        if (hsEdge) begin
            if (reqQ[hsId].size() > 0) req_data[8*hsId +: 8] = reqQ[hsId].pop_front();
            else                       req_valid[hsId] = 1'b0;
        end
    endtask

    task automatic post(input int i, input logic [7:0] b);
        if (!req_valid[i]) begin
            req_data[8*i +: 8] = b;
            req_valid[i] = 1'b1;
        end else begin
            reqQ[i].push_back(b);
        end
    endtask

    task automatic doReset();
        reset     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) reqQ[i].delete();
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    task automatic waitHs(input int budget, output bit ok);
        ok = 0;
        for (int w = 0; w < budget && !ok; w++) begin
            tick();
            ok = hsEdge;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_valid = '1;
        @(posedge clock);
        monOn = 1;
        @(negedge clock);
        tests++;
        if ({tx_en, busy, frame_done, data_in, grant_id, req_ready} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_outputs got=%h exp=0", {tx_en, busy, frame_done, data_in, grant_id, req_ready});
        end
        req_valid = '0;
        @(posedge clock);
        #1 reset = 1'b1;
        for (int c = 0; c < 500; c++) begin
            @(negedge clock);
            tests++;
            if ({tx_en, busy, frame_done, data_in, grant_id, req_ready} !== '0) begin
                fails++;
                $display("[TB] FAIL idle_outputs c=%0d got=%h exp=0", c, {tx_en, busy, frame_done, data_in, grant_id, req_ready});
            end
            tick();
        end
    endtask

    task automatic test_single();
        bit ok;
        doReset();
        post(2, 8'hA5);
        @(negedge clock);
        tests++;
        if (req_ready !== 4'b0100) begin
            fails++;
            $display("[TB] FAIL single_ready got=%b exp=0100", req_ready);
        end
        waitHs(5, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("[TB] FAIL single_handshake got=timeout exp=handshake");
        end
        for (int off = 1; off <= 226; off++) begin
            @(negedge clock);
            tests++;
            if (tx_en !== (off == 1)) begin
                fails++;
                $display("[TB] FAIL single_tx_en off=%0d got=%b exp=%b", off, tx_en, off == 1);
            end
            tests++;
            if (frame_done !== (off == FRAME)) begin
                fails++;
                $display("[TB] FAIL single_frame_done off=%0d got=%b exp=%b", off, frame_done, off == FRAME);
            end
            tests++;
            if (busy !== (off <= FRAME + GAP_CYCLES)) begin
                fails++;
                $display("[TB] FAIL single_busy off=%0d got=%b exp=%b", off, busy, off <= FRAME + GAP_CYCLES);
            end
            tests++;
            if (data_in !== 8'hA5 || grant_id !== 2'd2) begin
                fails++;
                $display("[TB] FAIL single_data_grant off=%0d got=%h/%0d exp=a5/2", off, data_in, grant_id);
            end
            tick();
        end
    endtask

    task automatic test_rotation();
        int         seen = 0;
        int         prevT = -1;
        int         expId[5];
        logic [7:0] expByte[5];
`ifdef UART_TXARB_FIXED_PRIO_EN
        expId   = '{0, 0, 1, 1, 2};
        expByte = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12};
`else
        expId   = '{0, 1, 2, 3, 0};
        expByte = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20};
`endif
        doReset();
        for (int i = 0; i < NUM_REQ; i++) begin
            post(i, 8'(8'h10 + i));
            post(i, 8'(8'h20 + i));
        end
        for (int c = 0; c < 6 * SLOT && seen < 5; c++) begin
            @(negedge clock);
            if (tx_en) begin
                tests++;
                if (grant_id !== IDW'(expId[seen])) begin
                    fails++;
                    $display("[TB] FAIL rotation_grant n=%0d got=%0d exp=%0d", seen, grant_id, expId[seen]);
                end
                tests++;
                if (data_in !== expByte[seen]) begin
                    fails++;
                    $display("[TB] FAIL rotation_data n=%0d got=%h exp=%h", seen, data_in, expByte[seen]);
                end
                if (prevT >= 0) begin
                    tests++;
                    if (tbCyc - prevT != SLOT) begin
                        fails++;
                        $display("[TB] FAIL rotation_spacing n=%0d got=%0d exp=%0d", seen, tbCyc - prevT, SLOT);
                    end
                end
                prevT = tbCyc;
                seen++;
            end
            tick();
        end
        tests++;
        if (seen != 5) begin
            fails++;
            $display("[TB] FAIL rotation_count got=%0d exp=5", seen);
        end
    endtask

    task automatic test_late_request();
        bit ok;
        doReset();
        post(3, 8'h3C);
        waitHs(5, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("[TB] FAIL late_first_hs got=timeout exp=handshake");
        end
        for (int off = 1; off <= 226; off++) begin
            @(negedge clock);
            if (off == 1) begin
                tests++;
                if (grant_id !== 2'd3) begin
                    fails++;
                    $display("[TB] FAIL late_first_grant got=%0d exp=3", grant_id);
                end
            end
            if (off >= 50 && off < SLOT) begin
                tests++;
                if (req_ready[1] !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL late_ready_busy off=%0d got=1 exp=0", off);
                end
            end
            if (off == SLOT) begin
                tests++;
                if (req_ready !== 4'b0010) begin
                    fails++;
                    $display("[TB] FAIL late_ready_idle got=%b exp=0010", req_ready);
                end
            end
            if (off == SLOT + 1) begin
                tests++;
                if (tx_en !== 1'b1 || grant_id !== 2'd1 || data_in !== 8'h77) begin
                    fails++;
                    $display("[TB] FAIL late_second_tx got=%b/%0d/%h exp=1/1/77", tx_en, grant_id, data_in);
                end
            end
            tick();
            if (off == 49) post(1, 8'h77);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        doReset();
        post(0, 8'h5A);
        waitHs(5, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("[TB] FAIL midrst_first_hs got=timeout exp=handshake");
        end
        repeat (99) tick();
        #2 reset = 1'b0;
        post(0, 8'hC3);
        #1;
        tests++;
        if ({tx_en, busy, frame_done, data_in, grant_id, req_ready} !== '0) begin
            fails++;
            $display("[TB] FAIL midrst_outputs got=%h exp=0", {tx_en, busy, frame_done, data_in, grant_id, req_ready});
        end
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        waitHs(3, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("[TB] FAIL midrst_second_hs got=timeout exp=handshake");
        end
        for (int off = 1; off <= FRAME + 1; off++) begin
            @(negedge clock);
            tests++;
            if (tx_en !== (off == 1) || frame_done !== (off == FRAME) || data_in !== 8'hC3) begin
                fails++;
                $display("[TB] FAIL midrst_frame off=%0d got=%b/%b/%h exp=%b/%b/c3", off, tx_en, frame_done, data_in, off == 1, off == FRAME);
            end
            tick();
        end
    endtask

    task automatic test_drop();
        bit ok;
        int txSeen = 0;
        doReset();
        post(0, 8'h01);
        waitHs(5, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("[TB] FAIL drop_first_hs got=timeout exp=handshake");
        end
        post(2, 8'h22);
        post(3, 8'h33);
        repeat (9) tick();
        req_valid[2] = 1'b0;
        for (int c = 0; c < 3 * SLOT; c++) begin
            @(negedge clock);
            if (tx_en) begin
                txSeen++;
                if (txSeen == 1) begin
                    tests++;
                    if (grant_id !== 2'd3 || data_in !== 8'h33) begin
                        fails++;
                        $display("[TB] FAIL drop_next_grant got=%0d/%h exp=3/33", grant_id, data_in);
                    end
                end
            end
            tick();
        end
        tests++;
        if (txSeen != 1) begin
            fails++;
            $display("[TB] FAIL drop_frame_count got=%0d exp=1", txSeen);
        end
    endtask

    task automatic test_random();
        int hs0;
        int txCnt = 0;
        doReset();
        hs0 = hsTotal;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clock);
            if (tx_en) txCnt++;
            tick();
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 99) < 3) begin
                    req_data[8*i +: 8] = 8'($urandom);
                    req_valid[i] = 1'b1;
                end else if (req_valid[i] && $urandom_range(0, 999) < 2) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        req_valid = '0;
        for (int c = 0; c < SLOT + 2; c++) begin
            @(negedge clock);
            if (tx_en) txCnt++;
            tick();
        end
        tests++;
        if (txCnt != hsTotal - hs0) begin
            fails++;
            $display("[TB] FAIL random_frame_count got=%0d exp=%0d", txCnt, hsTotal - hs0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_late_request();
        test_reset_mid_frame();
        test_drop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
